muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/muldiv_step.sv | 29 ++
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: funct3 op encodings, mul/div FSM states and
// operand-signedness helpers.
package riscv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } muldiv_state_e;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration on the 2*XLEN accumulator: shift-add for
// multiply (multiplier in the low half), restoring shift-subtract for divide.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_opnd,
  input  logic [2*XLEN-1:0] i_acc,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_mul;
  logic [2*XLEN-1:0] w_div;

  assign w_sum  = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_opnd};
  assign w_mul  = i_acc[0] ? {w_sum, i_acc[XLEN-1:1]} : {1'b0, i_acc[2*XLEN-1:1]};

  // Partial remainder is always below the divisor, so XLEN+1 bits hold the shift.
  assign w_rem  = i_acc[2*XLEN-1:XLEN-1];
  assign w_diff = w_rem - {1'b0, i_opnd};
  assign w_div  = w_diff[XLEN] ? {i_acc[2*XLEN-2:0], 1'b0}
                               : {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};

  assign o_acc  = i_is_div ? w_div : w_mul;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: sign-magnitude operands, UNROLL
// steps per clock, sign fix-up and half/quotient/remainder select at the end.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CNT_W = $clog2(STEPS + 1);

  muldiv_state_e     r_state;
  muldiv_state_e     w_next;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_opnd;
  logic [2*XLEN-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_a;
  logic              r_neg_b;
  logic              r_div0;
  logic [XLEN-1:0]   r_result;

  logic              w_is_div;
  logic              w_sa;
  logic              w_sb;
  logic              w_b_zero;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fixed;
  logic [2*XLEN-1:0] w_chain [UNROLL+1];

  assign w_is_div = r_op[2];
  assign w_sa     = op_a_signed(r_op) & r_a[XLEN-1];
  assign w_sb     = op_b_signed(r_op) & r_b[XLEN-1];
  assign w_mag_a  = w_sa ? -r_a : r_a;
  assign w_mag_b  = w_sb ? -r_b : r_b;
  assign w_b_zero = (r_b == '0);

  assign w_chain[0] = r_acc;
  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .i_is_div (w_is_div),
      .i_opnd   (r_opnd),
      .i_acc    (w_chain[gi]),
      .o_acc    (w_chain[gi+1])
    );
  end

  always_comb begin
    w_prod  = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
    w_quot  = (r_neg_a ^ r_neg_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem   = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    w_fixed = w_rem;
    if (r_div0) w_quot = '1;
    case (r_op)
      OP_MUL:                      w_fixed = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fixed = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             w_fixed = w_quot;
      default:                     w_fixed = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Divide by zero skips CALC but still passes through FIX, keeping a fixed
  // two-cycle latency and reusing the remainder sign fix-up to return a.
  always_comb begin
    w_next = r_state;
    busy   = (r_state != S_IDLE);
    done   = (r_state == S_DONE);
    case (r_state)
      S_IDLE: if (start) w_next = S_PREP;
      S_PREP: begin
        if (kill)                       w_next = S_IDLE;
        else if (w_is_div && w_b_zero)  w_next = S_FIX;
        else                            w_next = S_CALC;
      end
      S_CALC: begin
        if (kill)                          w_next = S_IDLE;
        else if (r_cnt == CNT_W'(1))       w_next = S_FIX;
      end
      S_FIX:   w_next = kill ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_div0   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
          end
        end
        S_PREP: begin
          r_neg_a <= w_sa;
          r_neg_b <= w_sb;
          r_cnt   <= CNT_W'(STEPS);
          r_div0  <= w_is_div & w_b_zero;
          if (w_is_div) begin
            r_opnd <= w_mag_b;
            r_acc  <= w_b_zero ? {w_mag_a, {XLEN{1'b0}}} : {{XLEN{1'b0}}, w_mag_a};
          end else begin
            r_opnd <= w_mag_a;
            r_acc  <= {{XLEN{1'b0}}, w_mag_b};
          end
        end
        S_CALC: begin
          r_acc <= w_chain[UNROLL];
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIX: if (!kill) r_result <= w_fixed;
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: table vectors and corner sequences on an UNROLL=1
// instance, random sweep and mid-operation reset on an UNROLL=4 instance.
module tb_muldiv_unit;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       name;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    string       name;
  } vec_t;

  logic        clk;
  logic        rst1_n, st1, kl1, busy1, done1;
  logic [2:0]  op1;
  logic [31:0] a1, b1, res1;
  logic        rst4_n, st4, kl4, busy4, done4;
  logic [2:0]  op4;
  logic [31:0] a4, b4, res4;

  int          checks;
  int          errors;
  logic [31:0] last1, last4;
  exp_t        sbq[$];

  muldiv_unit #(.XLEN(32), .UNROLL(1)) dut1 (
    .clk(clk), .reset_n(rst1_n), .start(st1), .kill(kl1), .op(op1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .result(res1)
  );

  muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (
    .clk(clk), .reset_n(rst4_n), .start(st4), .kill(kl4), .op(op4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .result(res4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic set_in(input bit u4, input logic s, input logic k, input logic [2:0] o,
                        input logic [31:0] av, input logic [31:0] bv);
    if (u4) begin st4 = s; kl4 = k; op4 = o; a4 = av; b4 = bv; end
    else    begin st1 = s; kl1 = k; op1 = o; a1 = av; b1 = bv; end
  endtask

  function automatic logic dn(input bit u4);
    return u4 ? done4 : done1;
  endfunction

  function automatic logic bsy(input bit u4);
    return u4 ? busy4 : busy1;
  endfunction

  function automatic logic [31:0] rs(input bit u4);
    return u4 ? res4 : res1;
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    logic [31:0]        r;
    sa = {{32{av[31]}}, av};
    sb = {{32{bv[31]}}, bv};
    ua = {32'b0, av};
    ub = {32'b0, bv};
    sp = '0;
    up = '0;
    r  = '0;
    case (o)
      3'd0: begin sp = sa * sb;          r = sp[31:0];  end
      3'd1: begin sp = sa * sb;          r = sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); r = sp[63:32]; end
      3'd3: begin up = ua * ub;          r = up[63:32]; end
      3'd4: begin if (bv == 0) r = '1; else begin sp = sa / sb; r = sp[31:0]; end end
      3'd5: begin if (bv == 0) r = '1; else r = av / bv; end
      3'd6: begin if (bv == 0) r = av; else begin sp = sa % sb; r = sp[31:0]; end end
      default: begin if (bv == 0) r = av; else r = av % bv; end
    endcase
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after done.
  task automatic do_op(input bit u4, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] er, input int el, input string nm,
                       input bit poke, input bit kst);
    exp_t        e;
    int          lat;
    logic [31:0] prev;
    prev = u4 ? last4 : last1;
    sbq.push_back('{res: er, lat: el, name: nm});
    set_in(u4, 1'b1, kst, o, av, bv);
    @(negedge clk);
    set_in(u4, 1'b0, 1'b0, ~o, ~av, bv ^ 32'h5a5a_5a5a);
    lat = 0;
    while (!dn(u4) && lat < 200) begin
      if (lat == 1) chk({nm, " hold"}, rs(u4), prev);
      set_in(u4, poke && (lat == 3), 1'b0, 3'd0, 32'd1, 32'd1);
      @(negedge clk);
      lat++;
    end
    e = sbq.pop_front();
    chk({e.name, " done"}, {31'b0, dn(u4)}, 32'd1);
    if (dn(u4)) begin
      chk({e.name, " result"}, rs(u4), e.res);
      chk({e.name, " latency"}, 32'(lat), 32'(e.lat));
      chk({e.name, " busy"}, {31'b0, bsy(u4)}, 32'd1);
    end
    if (u4) last4 = e.res; else last1 = e.res;
    @(negedge clk);
    chk({e.name, " pulse"}, {31'b0, dn(u4)}, 32'd0);
    chk({e.name, " idle"}, {31'b0, bsy(u4)}, 32'd0);
  endtask

  initial begin
    vec_t        tbl[13];
    int          seen;
    logic [31:0] ra, rb;
    clk    = 1'b0;
    checks = 0;
    errors = 0;
    last1  = '0;
    last4  = '0;
    rst1_n = 1'b0;
    rst4_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
    set_in(1'b1, 1'b0, 1'b0, 3'd0, '0, '0);

    tbl[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "MUL 7*-3"};
    tbl[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "MULH min*min"};
    tbl[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "MULHU ones"};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "MULHSU -1"};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "DIV -7/2"};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "REM -7/2"};
    tbl[6]  = '{3'd5, 32'h8000_0000, 32'h8000_0000, 32'd1,         34, "DIVU min/min"};
    tbl[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "DIV overflow"};
    tbl[8]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34, "REM overflow"};
    tbl[9]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 2,  "DIVU 5/0"};
    tbl[10] = '{3'd7, 32'd5,         32'd0,         32'd5,         2,  "REMU 5/0"};
    tbl[11] = '{3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 2,  "DIV -7/0"};
    tbl[12] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 2,  "REM -7/0"};

    repeat (2) @(negedge clk);
    chk("reset busy1", {31'b0, busy1}, 32'd0);
    chk("reset done1", {31'b0, done1}, 32'd0);
    chk("reset result1", res1, 32'd0);
    chk("reset busy4", {31'b0, busy4}, 32'd0);
    chk("reset done4", {31'b0, done4}, 32'd0);
    chk("reset result4", res4, 32'd0);
    rst1_n = 1'b1;
    rst4_n = 1'b1;

    // Back-to-back table; vector 0 also pokes start while busy, vector 2 raises kill with start.
    for (int i = 0; i < 13; i++)
      do_op(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat, tbl[i].name,
            i == 0, i == 2);

    // Kill in the tenth CALC cycle of a DIV.
    set_in(1'b0, 1'b1, 1'b0, 3'd4, 32'd100, 32'd7);
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
    repeat (10) @(negedge clk);
    chk("kill busy before", {31'b0, busy1}, 32'd1);
    kl1 = 1'b1;
    @(negedge clk);
    kl1 = 1'b0;
    chk("kill busy after", {31'b0, busy1}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1) seen++;
    end
    chk("kill no done", 32'(seen), 32'd0);
    chk("kill result kept", res1, last1);
    do_op(1'b0, 3'd0, 32'd3, 32'd4, 32'd12, 34, "MUL 3*4 after kill", 1'b0, 1'b0);

    // Random sweep on UNROLL=4 against the reference model.
    for (int o = 0; o < 8; o++) begin
      for (int k = 0; k < 6; k++) begin
        ra = $urandom;
        rb = $urandom;
        if (k == 0) rb = '0;
        if (k == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        if (k == 2) rb = rb >> 20;
        do_op(1'b1, 3'(o), ra, rb, ref_md(3'(o), ra, rb),
              (o >= 4 && rb == 0) ? 2 : 10, $sformatf("rand op%0d #%0d", o, k), 1'b0, 1'b0);
      end
    end

    // Asynchronous reset in the middle of CALC.
    set_in(1'b1, 1'b1, 1'b0, 3'd0, 32'd9, 32'd9);
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 3'd0, '0, '0);
    repeat (4) @(negedge clk);
    #2 rst4_n = 1'b0;
    #1;
    chk("rst mid busy", {31'b0, busy4}, 32'd0);
    chk("rst mid done", {31'b0, done4}, 32'd0);
    chk("rst mid result", res4, 32'd0);
    @(negedge clk);
    rst4_n = 1'b1;
    last4  = '0;
    seen   = 0;
    repeat (15) begin
      @(negedge clk);
      if (done4) seen++;
    end
    chk("rst no done", 32'(seen), 32'd0);
    do_op(1'b1, 3'd0, 32'd6, 32'd7, 32'd42, 10, "MUL 6*7 after reset", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
